alarm_unit: RTL



---
 rtl/alarm_pkg.sv | 22 ++
 rtl/alarm_bcd_inc.sv | 45 ++++
 rtl/alarm_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared alarm types and BCD limits; counter width grows when ALARM_SNOOZE_EN is defined.
package alarm_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } alarm_state_t;

    localparam logic [3:0] UNITS_MAX          = 4'd9;
    localparam logic [2:0] MIN_TENS_MAX       = 3'd5;
    localparam logic [1:0] HOUR_TENS_MAX      = 2'd2;
    localparam logic [3:0] HOUR_UNITS_AT_MAX  = 4'd3;

`ifdef ALARM_SNOOZE_EN
    localparam int CNT_W = 9;
`else
    localparam int CNT_W = 8;
`endif

endpackage

// File: rtl/alarm_bcd_inc.sv
// Combinational HH:MM BCD incrementer with independent minute/hour enables.
// Minutes wrap 59->00 without carrying; hours wrap 23->00.
module alarm_bcd_inc (
    input  logic       inc_min,
    input  logic       inc_hour,
    input  logic [3:0] units_min,
    input  logic [2:0] tens_min,
    input  logic [3:0] units_hour,
    input  logic [1:0] tens_hour,
    output logic [3:0] next_units_min,
    output logic [2:0] next_tens_min,
    output logic [3:0] next_units_hour,
    output logic [1:0] next_tens_hour
);
    import alarm_pkg::*;

    always_comb begin
        next_units_min  = units_min;
        next_tens_min   = tens_min;
        next_units_hour = units_hour;
        next_tens_hour  = tens_hour;

        if (inc_min) begin
            if (units_min == UNITS_MAX) begin
                next_units_min = 4'd0;
                next_tens_min  = (tens_min == MIN_TENS_MAX) ? 3'd0 : tens_min + 3'd1;
            end else begin
                next_units_min = units_min + 4'd1;
            end
        end

        if (inc_hour) begin
            if (tens_hour == HOUR_TENS_MAX && units_hour == HOUR_UNITS_AT_MAX) begin
                next_units_hour = 4'd0;
                next_tens_hour  = 2'd0;
            end else if (units_hour == UNITS_MAX) begin
                next_units_hour = 4'd0;
                next_tens_hour  = tens_hour + 2'd1;
            end else begin
                next_units_hour = units_hour + 4'd1;
            end
        end
    end

endmodule

// File: rtl/alarm_unit.sv
// Alarm compare/ring FSM with BCD alarm-time edit and 2 Hz gated buzzer.
// Optional snooze state compiled in with ALARM_SNOOZE_EN.
module alarm_unit #(
    parameter int unsigned RING_SECONDS   = 60,
    parameter int unsigned SNOOZE_SECONDS = 300
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Enable_1Hz,
    input  logic       i_Clock_2Hz,
    input  logic [3:0] i_Units_Min,
    input  logic [2:0] i_Tens_Min,
    input  logic [3:0] i_Units_Hour,
    input  logic [1:0] i_Tens_Hour,
    input  logic [1:0] i_Edit_Enable,
    input  logic       i_Increment,
    input  logic       i_Arm_Toggle,
    input  logic       i_Stop,
    output logic [3:0] o_Alarm_Units_Min,
    output logic [2:0] o_Alarm_Tens_Min,
    output logic [3:0] o_Alarm_Units_Hour,
    output logic [1:0] o_Alarm_Tens_Hour,
    output logic       o_Armed,
    output logic       o_Ringing,
    output logic       o_Buzzer
);
    import alarm_pkg::*;

    if (RING_SECONDS < 1 || RING_SECONDS > 255 || SNOOZE_SECONDS < 1 || SNOOZE_SECONDS > 511) begin : g_bad_params
        $error("alarm_unit: RING_SECONDS or SNOOZE_SECONDS out of range");
    end

    localparam logic [CNT_W:0] RING_LIM = RING_SECONDS[CNT_W:0];

    alarm_state_t     state, state_next;
    logic [3:0]       a_units_min, a_units_hour, n_units_min, n_units_hour;
    logic [2:0]       a_tens_min, n_tens_min;
    logic [1:0]       a_tens_hour, n_tens_hour;
    logic             match_now, match_r, match_q, trigger;
    logic             tick_run, ring_done;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W:0]   cnt_inc;
    logic             buzzer_q;

    alarm_bcd_inc u_inc (
        .inc_min         (i_Increment & i_Edit_Enable[0]),
        .inc_hour        (i_Increment & i_Edit_Enable[1]),
        .units_min       (a_units_min),
        .tens_min        (a_tens_min),
        .units_hour      (a_units_hour),
        .tens_hour       (a_tens_hour),
        .next_units_min  (n_units_min),
        .next_tens_min   (n_tens_min),
        .next_units_hour (n_units_hour),
        .next_tens_hour  (n_tens_hour)
    );

    assign match_now = (i_Units_Min == a_units_min) && (i_Tens_Min == a_tens_min) &&
                       (i_Units_Hour == a_units_hour) && (i_Tens_Hour == a_tens_hour);
    // Rising edge of the registered match, so an already-matching time never rings on arm.
    assign trigger   = match_r & ~match_q;

    assign tick_run  = i_Enable_1Hz && (state == RINGING || state == SNOOZE);
    assign cnt_inc   = {1'b0, cnt} + (CNT_W + 1)'(1);
    assign ring_done = tick_run && (cnt_inc == RING_LIM);

`ifdef ALARM_SNOOZE_EN
    localparam logic [CNT_W:0] SNOOZE_LIM = SNOOZE_SECONDS[CNT_W:0];
    logic snooze_done;
    assign snooze_done = tick_run && (cnt_inc == SNOOZE_LIM);
`endif

    always_comb begin
        state_next = state;
        case (state)
            DISARMED: begin
                if (i_Arm_Toggle) state_next = ARMED;
            end
            ARMED: begin
                if (i_Arm_Toggle)  state_next = DISARMED;
                else if (trigger)  state_next = RINGING;
            end
            RINGING: begin
                if (i_Arm_Toggle)   state_next = DISARMED;
`ifdef ALARM_SNOOZE_EN
                else if (i_Stop)    state_next = SNOOZE;
`else
                else if (i_Stop)    state_next = ARMED;
`endif
                else if (ring_done) state_next = ARMED;
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (i_Arm_Toggle)     state_next = DISARMED;
                else if (i_Stop)      state_next = ARMED;
                else if (snooze_done) state_next = RINGING;
            end
`endif
            default: state_next = DISARMED;
        endcase
    end

    always_comb begin
        cnt_next = cnt;
        if (state_next != state) cnt_next = '0;
        else if (tick_run)       cnt_next = cnt_inc[CNT_W-1:0];
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state        <= DISARMED;
            cnt          <= '0;
            match_r      <= 1'b0;
            match_q      <= 1'b0;
            buzzer_q     <= 1'b0;
            a_units_min  <= 4'd0;
            a_tens_min   <= 3'd0;
            a_units_hour <= 4'd0;
            a_tens_hour  <= 2'd0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            match_r      <= match_now;
            match_q      <= match_r;
            buzzer_q     <= (state == RINGING) & i_Clock_2Hz;
            a_units_min  <= n_units_min;
            a_tens_min   <= n_tens_min;
            a_units_hour <= n_units_hour;
            a_tens_hour  <= n_tens_hour;
        end
    end

    assign o_Armed            = (state != DISARMED);
    assign o_Ringing          = (state == RINGING);
    assign o_Buzzer           = buzzer_q;
    assign o_Alarm_Units_Min  = a_units_min;
    assign o_Alarm_Tens_Min   = a_tens_min;
    assign o_Alarm_Units_Hour = a_units_hour;
    assign o_Alarm_Tens_Hour  = a_tens_hour;

endmodule
